// File: rtl/feed_scheduler.sv
// feed_scheduler: minute-of-day clock with four meal slots and a request
// queue that feeds the dispenser FSM through timesup / feed_ack.
// Ports:
//   clk, reset (sync, active-high)
//   sec_tick - 1 Hz one-cycle pulse
//   set_time_we, set_minute - load time of day (0..1439)
//   cfg_we, cfg_slot, cfg_minute, cfg_enable - program a meal slot
//   feed_ack - dispenser finished a feed
//   timesup - level meal request
//   newday - one-cycle pulse at midnight wrap
//   minute_of_day - current time
//   pending_count - queued requests (0..3)
//   missed_meal - sticky, a request was dropped on a full queue
module feed_scheduler #(
    parameter int TICKS_PER_MIN  = 60,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sec_tick,
    input  logic        set_time_we,
    input  logic [10:0] set_minute,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_slot,
    input  logic [10:0] cfg_minute,
    input  logic        cfg_enable,
    input  logic        feed_ack,
    output logic        timesup,
    output logic        newday,
    output logic [10:0] minute_of_day,
    output logic [1:0]  pending_count,
    output logic        missed_meal
);

    localparam int SW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [SW-1:0] SEC_TOP = SW'(TICKS_PER_MIN - 1);
    localparam logic [HW-1:0] HOLD_TOP = HW'(HOLDOFF_CYCLES - 1);
    localparam logic [10:0] LAST_MIN = 11'd1439;
    localparam logic [10:0] DAY_MIN = 11'd1440;

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t        state;
    logic [SW-1:0] sec_cnt;
    logic [HW-1:0] hold_cnt;
    logic [10:0]   slot_min [4];
    logic          slot_en  [4];

    logic        load;
    logic        step;
    logic        wrap;
    logic [10:0] next_min;
    logic        match;
    logic        req;
    logic        ack;
    logic        drop;

    always_comb begin
        // A valid time load wins over a coincident tick, which is lost.
        load     = set_time_we && (set_minute < DAY_MIN);
        step     = sec_tick && !load && (sec_cnt == SEC_TOP);
        wrap     = (minute_of_day == LAST_MIN);
        next_min = wrap ? 11'd0 : minute_of_day + 11'd1;
        // Slots are matched against the minute being entered, using
        // pre-write slot contents so a same-cycle cfg write lands after.
        match    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (slot_en[i] && (slot_min[i] == next_min)) begin
                match = 1'b1;
            end
        end
        req  = step && match;
        ack  = (state == REQ) && feed_ack;
        // A coincident ack frees a place, so a request at 3 is kept.
        drop = req && !ack && (pending_count == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_cnt       <= '0;
            minute_of_day <= '0;
            newday        <= 1'b0;
            pending_count <= '0;
            missed_meal   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_min[i] <= '0;
                slot_en[i]  <= 1'b0;
            end
        end else begin
            if (load) begin
                minute_of_day <= set_minute;
                sec_cnt       <= '0;
            end else if (sec_tick) begin
                if (sec_cnt == SEC_TOP) begin
                    sec_cnt       <= '0;
                    minute_of_day <= next_min;
                end else begin
                    sec_cnt <= sec_cnt + SW'(1);
                end
            end

            newday <= step && wrap;

            if (cfg_we && (cfg_minute < DAY_MIN)) begin
                slot_min[cfg_slot] <= cfg_minute;
                slot_en[cfg_slot]  <= cfg_enable;
            end

            if (req && !ack) begin
                if (pending_count != 2'd3) begin
                    pending_count <= pending_count + 2'd1;
                end
            end else if (ack && !req) begin
                pending_count <= pending_count - 2'd1;
            end

            // Drop outranks the midnight clear so the flag ends set.
            if (drop) begin
                missed_meal <= 1'b1;
            end else if (step && wrap) begin
                missed_meal <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            timesup  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pending_count != 2'd0) begin
                        state   <= REQ;
                        timesup <= 1'b1;
                    end
                end
                REQ: begin
                    if (feed_ack) begin
                        state    <= HOLD;
                        timesup  <= 1'b0;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_TOP) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    timesup <= 1'b0;
                end
            endcase
        end
    end

endmodule
